// File: rtl/ppfifo_mem_bank_scheduler.sv
// Ping-pong bank scheduler: arms writer banks 0/1 alternately, detects fills,
// hands full banks to the host and re-arms them after release.
module ppfifo_mem_bank_scheduler #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH-1:0] i_bank_0_base,
  input  logic [ADDR_WIDTH-1:0] i_bank_1_base,
  input  logic [ADDR_WIDTH-1:0] i_bank_size,
  input  logic [ADDR_WIDTH-1:0] i_buffer_total,
  input  logic [1:0]            i_bank_release,
  input  logic                  i_memory_0_empty,
  input  logic                  i_memory_1_empty,
  output logic                  o_enable,
  output logic [ADDR_WIDTH-1:0] o_memory_0_base,
  output logic [ADDR_WIDTH-1:0] o_memory_0_size,
  output logic                  o_memory_0_new_data,
  output logic [ADDR_WIDTH-1:0] o_memory_1_base,
  output logic [ADDR_WIDTH-1:0] o_memory_1_size,
  output logic                  o_memory_1_new_data,
  output logic [1:0]            o_bank_full,
  output logic                  o_fill_done,
  output logic [ADDR_WIDTH-1:0] o_buffers_written,
  output logic                  o_busy,
  output logic                  o_cfg_err
);

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DRAIN} top_t;
  typedef enum logic [2:0] {B_FREE, B_ARM, B_SETTLE, B_FILLING, B_FULL} bank_t;

  top_t                  top_q, top_d;
  bank_t                 bank_q [2];
  bank_t                 bank_d [2];
  logic [3:0]            settle_q [2];
  logic                  ptr_q;
  logic [ADDR_WIDTH-1:0] armed_q, total_q, base0_q, base1_q, size_q, written_q;
  logic                  fill_done_q, cfg_err_q;

  logic                  start_ok, start_bad, quota_ok, arm_go;
  logic [1:0]            mem_empty, inflight, complete, fill_cnt;

  assign mem_empty = {i_memory_1_empty, i_memory_0_empty};
  assign start_ok  = (top_q == T_IDLE) && i_start && (i_bank_size != '0);
  assign start_bad = (top_q == T_IDLE) && i_start && (i_bank_size == '0);
  assign quota_ok  = (total_q == '0) || (armed_q < total_q);
  // The arm is committed (counted, pointer flipped) on the FREE->ARM edge so the
  // other bank can be committed while this one is pulsing new_data.
  assign arm_go    = (top_q == T_RUN) && !i_stop && quota_ok && (bank_q[ptr_q] == B_FREE);
  assign fill_cnt  = {1'b0, complete[0]} + {1'b0, complete[1]};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      inflight[n] = (bank_q[n] == B_ARM) || (bank_q[n] == B_SETTLE) || (bank_q[n] == B_FILLING);
      complete[n] = (bank_q[n] == B_FILLING) && mem_empty[n];
    end
  end

  // Top FSM next state
  always_comb begin
    top_d = top_q;
    case (top_q)
      T_IDLE:  if (start_ok) top_d = T_RUN;
      T_RUN:   if (i_stop || ((total_q != '0) && (armed_q == total_q))) top_d = T_DRAIN;
      T_DRAIN: if (inflight == 2'b00) top_d = T_IDLE;
      default: top_d = T_IDLE;
    endcase
  end

  // Bank FSM next state
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      bank_d[n] = bank_q[n];
      case (bank_q[n])
        B_FREE:    if (arm_go && (ptr_q == 1'(n))) bank_d[n] = B_ARM;
        B_ARM:     bank_d[n] = B_SETTLE;
        B_SETTLE:  if (settle_q[n] == 4'(SETTLE_CYCLES - 1)) bank_d[n] = B_FILLING;
        B_FILLING: if (complete[n]) bank_d[n] = B_FULL;
        B_FULL:    if (i_bank_release[n]) bank_d[n] = B_FREE;
        default:   bank_d[n] = B_FREE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= T_IDLE;
      ptr_q       <= 1'b0;
      armed_q     <= '0;
      total_q     <= '0;
      base0_q     <= '0;
      base1_q     <= '0;
      size_q      <= '0;
      written_q   <= '0;
      fill_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        bank_q[n]   <= B_FREE;
        settle_q[n] <= '0;
      end
    end else begin
      top_q       <= top_d;
      fill_done_q <= |complete;
      cfg_err_q   <= start_bad;
      for (int n = 0; n < 2; n++) begin
        bank_q[n]   <= bank_d[n];
        settle_q[n] <= (bank_q[n] == B_SETTLE) ? settle_q[n] + 4'd1 : 4'd0;
      end
      if (start_ok) begin
        base0_q   <= i_bank_0_base;
        base1_q   <= i_bank_1_base;
        size_q    <= i_bank_size;
        total_q   <= i_buffer_total;
        written_q <= '0;
        armed_q   <= '0;
        ptr_q     <= 1'b0;
      end else begin
        written_q <= written_q + ADDR_WIDTH'(fill_cnt);
        if (arm_go) begin
          armed_q <= armed_q + 1'b1;
          ptr_q   <= ~ptr_q;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    o_enable            = (top_q != T_IDLE);
    o_busy              = (top_q != T_IDLE);
    o_memory_0_base     = base0_q;
    o_memory_1_base     = base1_q;
    o_memory_0_size     = size_q;
    o_memory_1_size     = size_q;
    o_memory_0_new_data = (bank_q[0] == B_ARM);
    o_memory_1_new_data = (bank_q[1] == B_ARM);
    o_bank_full         = {bank_q[1] == B_FULL, bank_q[0] == B_FULL};
    o_fill_done         = fill_done_q;
    o_buffers_written   = written_q;
    o_cfg_err           = cfg_err_q;
  end

endmodule

// File: tb/tb_ppfifo_mem_bank_scheduler.sv
// Randomized bench for ppfifo_mem_bank_scheduler against a timestamp-based
// model of the bank lifecycle plus a simple writer that drops empty after each arm.
module tb_ppfifo_mem_bank_scheduler;
  localparam int S  = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_start, i_stop, i_memory_0_empty, i_memory_1_empty;
  logic [AW-1:0] i_bank_0_base, i_bank_1_base, i_bank_size, i_buffer_total;
  logic [1:0]    i_bank_release;
  logic          o_enable, o_memory_0_new_data, o_memory_1_new_data, o_fill_done, o_busy, o_cfg_err;
  logic [AW-1:0] o_memory_0_base, o_memory_0_size, o_memory_1_base, o_memory_1_size, o_buffers_written;
  logic [1:0]    o_bank_full;

  ppfifo_mem_bank_scheduler #(.SETTLE_CYCLES(S), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_bank_0_base(i_bank_0_base), .i_bank_1_base(i_bank_1_base),
    .i_bank_size(i_bank_size), .i_buffer_total(i_buffer_total),
    .i_bank_release(i_bank_release),
    .i_memory_0_empty(i_memory_0_empty), .i_memory_1_empty(i_memory_1_empty),
    .o_enable(o_enable),
    .o_memory_0_base(o_memory_0_base), .o_memory_0_size(o_memory_0_size),
    .o_memory_0_new_data(o_memory_0_new_data),
    .o_memory_1_base(o_memory_1_base), .o_memory_1_size(o_memory_1_size),
    .o_memory_1_new_data(o_memory_1_new_data),
    .o_bank_full(o_bank_full), .o_fill_done(o_fill_done),
    .o_buffers_written(o_buffers_written), .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  // Model: age[n] = cycles since bank n's new_data pulse (-1 when not in flight);
  // age 0 is the pulse, 1..S settling, beyond S the bank watches its empty flag.
  bit            m_run, m_drain, m_done, m_err, m_ptr;
  bit            m_full [2];
  int            m_age [2];
  int            emp_cnt [2];
  logic [AW-1:0] m_armed, m_total, m_b0, m_b1, m_sz, m_wr;

  int total_n = 0;
  int bad_n   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_done = 0; m_err = 0; m_ptr = 0;
    m_armed = '0; m_total = '0; m_b0 = '0; m_b1 = '0; m_sz = '0; m_wr = '0;
    for (int n = 0; n < 2; n++) begin
      m_full[n] = 0; m_age[n] = -1; emp_cnt[n] = 0;
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit sp, input logic [1:0] rel,
                      input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                      input logic [AW-1:0] sz, input logic [AW-1:0] tot);
    logic [1:0] emp;
    bit idle, infl, commit, to_drain;
    bit comp [2];
    int ncomp, p;
    @(negedge clk);
    check("enable",  64'(o_enable), 64'(m_run | m_drain));
    check("busy",    64'(o_busy), 64'(m_run | m_drain));
    check("nd0",     64'(o_memory_0_new_data), 64'(m_age[0] == 0));
    check("nd1",     64'(o_memory_1_new_data), 64'(m_age[1] == 0));
    check("full",    64'(o_bank_full), 64'({m_full[1], m_full[0]}));
    check("done",    64'(o_fill_done), 64'(m_done));
    check("cfg_err", 64'(o_cfg_err), 64'(m_err));
    check("written", 64'(o_buffers_written), 64'(m_wr));
    check("base0",   64'(o_memory_0_base), 64'(m_b0));
    check("base1",   64'(o_memory_1_base), 64'(m_b1));
    check("size01",  {o_memory_1_size, o_memory_0_size}, {m_sz, m_sz});

    emp = {emp_cnt[1] == 0, emp_cnt[0] == 0};
    rst = rs; i_start = st; i_stop = sp; i_bank_release = rel;
    i_bank_0_base = b0; i_bank_1_base = b1; i_bank_size = sz; i_buffer_total = tot;
    i_memory_0_empty = emp[0]; i_memory_1_empty = emp[1];

    if (rs) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++) begin
      if (m_age[n] == 0) emp_cnt[n] = int'($urandom_range(8, 1));
      else if (emp_cnt[n] > 0) emp_cnt[n]--;
    end

    idle     = !m_run && !m_drain;
    infl     = (m_age[0] >= 0) || (m_age[1] >= 0);
    p        = int'(m_ptr);
    commit   = m_run && !sp && (m_total == 0 || m_armed < m_total) && m_age[p] < 0 && !m_full[p];
    to_drain = m_run && (sp || (m_total != 0 && m_armed == m_total));
    ncomp    = 0;
    for (int n = 0; n < 2; n++) begin
      comp[n] = (m_age[n] > S) && emp[n];
      if (comp[n]) begin
        ncomp++; m_age[n] = -1; m_full[n] = 1;
      end else if (m_age[n] >= 0) begin
        m_age[n]++;
      end else if (m_full[n] && rel[n]) begin
        m_full[n] = 0;
      end
    end
    if (commit) begin
      m_age[p] = 0; m_armed++; m_ptr = !m_ptr;
    end
    m_done = (ncomp > 0);
    m_wr   = m_wr + AW'(ncomp);
    m_err  = idle && st && (sz == 0);
    if (idle && st && sz != 0) begin
      m_run = 1; m_b0 = b0; m_b1 = b1; m_sz = sz; m_total = tot;
      m_wr = '0; m_armed = '0; m_ptr = 0;
    end else if (to_drain) begin
      m_run = 0; m_drain = 1;
    end else if (m_drain && !infl) begin
      m_drain = 0;
    end
  endtask

  task automatic phase(input int ncyc, input bit fs, input int p_start, input int p_stop,
                       input int p_rel, input int p_rst, input logic [AW-1:0] tot, input int sz);
    for (int c = 0; c < ncyc; c++) begin
      bit st, sp, rs;
      logic [1:0] rel;
      logic [AW-1:0] szv;
      st  = (fs && c == 0) || (int'($urandom_range(99)) < p_start);
      sp  = int'($urandom_range(99)) < p_stop;
      rs  = int'($urandom_range(99)) < p_rst;
      rel = {int'($urandom_range(99)) < p_rel, int'($urandom_range(99)) < p_rel};
      szv = (sz < 0) ? AW'($urandom_range(15)) : AW'(sz);
      step(rs, st, sp, rel, $urandom, $urandom, szv, tot);
    end
  endtask

  initial begin
    rst = 1; i_start = 0; i_stop = 0; i_bank_release = 0;
    i_bank_0_base = 0; i_bank_1_base = 0; i_bank_size = 0; i_buffer_total = 0;
    i_memory_0_empty = 1; i_memory_1_empty = 1;
    repeat (2) @(posedge clk);
    model_reset();
    phase(3, 0, 0, 0, 0, 100, 0, 4);        // reset values
    phase(60, 1, 0, 0, 100, 0, 2, 4);       // two fills, immediate release
    phase(80, 1, 0, 0, 0, 0, 0, 7);         // continuous, never released
    phase(60, 0, 0, 0, 20, 0, 0, 7);        // sparse releases keep order
    phase(40, 0, 0, 100, 100, 0, 0, 4);     // drain to idle
    phase(6, 1, 0, 0, 0, 0, 1, 0);          // zero-size start rejected
    phase(120, 1, 10, 4, 40, 0, 0, -1);     // stops mid-fill
    phase(120, 1, 10, 2, 50, 3, 3, -1);     // resets mid-run
    for (int k = 0; k < 8; k++)
      phase(90, 1, int'($urandom_range(10)), int'($urandom_range(6)),
            int'($urandom_range(100)), int'($urandom_range(2)),
            AW'($urandom_range(4)), -1);
    phase(60, 0, 0, 100, 100, 0, 0, 4);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/ppfifo_mem_bank_scheduler.md
Name: ppfifo_mem_bank_scheduler

Overview:
Sequences the dual-bank ping-pong FIFO-to-memory writer. It arms memory bank 0 and bank 1 alternately with base/size, pulses the per-bank new-data strobes, and detects when each bank is full. It hands full banks to the host and re-arms a bank only after the host releases it. It sits between the host register file and the writer's bank-control inputs.

Parameters:
SETTLE_CYCLES, 2, cycles after a new_data pulse before the bank's empty flag is sampled (covers writer flag latency); legal range 1-15.
ADDR_WIDTH, 32, width of base/size/count fields.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
i_start  input  1  one-cycle pulse; begin a run
i_stop  input  1  one-cycle pulse; stop arming, drain, go idle
i_bank_0_base  input  ADDR_WIDTH  bank 0 base address
i_bank_1_base  input  ADDR_WIDTH  bank 1 base address
i_bank_size  input  ADDR_WIDTH  words per bank fill
i_buffer_total  input  ADDR_WIDTH  fills to perform; 0 = continuous
i_bank_release  input  2  host pulse per bank: bank contents consumed
i_memory_0_empty  input  1  writer: bank 0 has no outstanding words
i_memory_1_empty  input  1  writer: bank 1 has no outstanding words
o_enable  output  1  writer enable
o_memory_0_base  output  ADDR_WIDTH  bank 0 base to writer
o_memory_0_size  output  ADDR_WIDTH  bank 0 size to writer
o_memory_0_new_data  output  1  one-cycle arm pulse, bank 0
o_memory_1_base  output  ADDR_WIDTH  bank 1 base to writer
o_memory_1_size  output  ADDR_WIDTH  bank 1 size to writer
o_memory_1_new_data  output  1  one-cycle arm pulse, bank 1
o_bank_full  output  2  per bank: filled, awaiting release
o_fill_done  output  1  one-cycle pulse per completed fill
o_buffers_written  output  ADDR_WIDTH  completed fills this run
o_busy  output  1  run in progress (RUN or DRAIN)
o_cfg_err  output  1  one-cycle pulse: start rejected

Behaviour:
- Reset: every output is 0. Both bank FSMs go to FREE, the top FSM goes to IDLE, and the arm pointer goes to bank 0. A reset mid-run discards all state; no drain is performed.
- Top FSM:
  - IDLE: on i_start with i_bank_size==0, pulse o_cfg_err and stay in IDLE.
  - IDLE: on any other i_start, latch bases/size/total, clear o_buffers_written, clear the armed counter, set pointer=0, go to RUN. o_enable=1 and o_busy=1 in RUN and DRAIN.
  - RUN: go to DRAIN on i_stop, or when total!=0 and armed==total.
  - DRAIN: go to IDLE when neither bank is ARM/SETTLE/FILLING.
  - i_start outside IDLE is ignored.
- Bank FSM per bank N, states FREE -> ARM -> SETTLE -> FILLING -> FULL -> FREE:
  - FREE->ARM: top in RUN, pointer==N, armed<total (or total==0), no i_stop this cycle.
  - ARM: one cycle. o_memory_N_new_data=1, armed+=1, pointer toggles. base/size outputs already hold latched values from the start cycle.
  - SETTLE: count SETTLE_CYCLES, then go to FILLING.
  - FILLING->FULL: when i_memory_N_empty==1. In that cycle, set o_bank_full[N], pulse o_fill_done, and increment o_buffers_written (wraps at 2^ADDR_WIDTH).
  - FULL->FREE: on i_bank_release[N]. o_bank_full[N] clears the next cycle.
- i_bank_release for a bank not in FULL is ignored.
- At most one new_data pulse per cycle. Pointer strictly alternates, so bank 1 is never armed twice in a row. If the pointer's bank is FULL, arming stalls even if the other bank is FREE; order is preserved.
- Both banks reaching FULL in the same cycle: o_fill_done is high for exactly one cycle and o_buffers_written increments by 2.
- i_stop during FILLING: the bank completes normally to FULL; o_bank_full stays valid after IDLE until released.
- Latency: i_start to first new_data is 2 cycles (RUN entry, then ARM).

Test Plan:
- i_start with size=4, total=2, base0=0x100, base1=0x200; model empties 6 cycles after each pulse; release each bank immediately -> new_data0 at cycle 2, new_data1 at cycle 3, two o_fill_done pulses, buffers_written=2, o_busy falls, o_enable=0.
- Continuous mode (total=0), host never releases -> both banks FULL, no third new_data, o_busy stays 1; release bank 0 -> bank 0 re-armed next cycle.
- Strict ordering: bank 1 FULL and unreleased, bank 0 FREE with pointer=1 -> no arm until release[1].
- i_stop while bank 0 FILLING -> bank 0 reaches FULL, buffers_written increments, no further arms, then IDLE.
- i_start with size=0 -> o_cfg_err pulse, o_busy stays 0, no new_data.
- rst asserted while FILLING -> all outputs 0 the next cycle; a later i_start arms bank 0 first.
